// File: rtl/determ_accum_fxp.sv
// determ_accum_fxp
//   Window averager placed after the deterministic-bitstream x FXP multiplier.
//   Each accepted cycle carries a signed sample x (+b or -b). The block sums
//   2^LOG2_LEN samples, divides by the window length with an arithmetic shift
//   and emits one registered average per window.
//
// Parameters
//   BIT_WIDTH  width of the signed input sample and the output average
//   LOG2_LEN   log2 of the window length N (legal range 1..16)
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   RST        asynchronous active-high reset
//   start      open a window from IDLE, or abort/restart the open window
//   in_valid   x carries a sample this cycle
//   x          signed sample from the multiplier
//   y          signed window average, held between out_valid pulses
//   out_valid  one-cycle pulse marking a new y
//   busy       a window is in progress
//
// Configuration
//   DETERM_ACCUM_ROUND_EN  defined: round half toward +inf when dividing.
//                          undefined: floor (plain arithmetic shift).

module determ_accum_fxp #(
  parameter int BIT_WIDTH = 16,
  parameter int LOG2_LEN  = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] x,
  output logic [BIT_WIDTH-1:0] y,
  output logic                 out_valid,
  output logic                 busy
);

  // N samples of BIT_WIDTH bits can never exceed BIT_WIDTH+LOG2_LEN bits.
  localparam int ACC_W = BIT_WIDTH + LOG2_LEN;
  localparam logic [LOG2_LEN-1:0] CNT_LAST = {LOG2_LEN{1'b1}};
  localparam logic [LOG2_LEN-1:0] CNT_ONE  = LOG2_LEN'(1'b1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] acc_nxt_s;
  logic signed [ACC_W-1:0] x_ext_s;
  logic signed [ACC_W-1:0] sum_s;
  logic [LOG2_LEN-1:0]   cnt_r;
  logic [LOG2_LEN-1:0]   cnt_nxt_s;
  logic [BIT_WIDTH-1:0]  y_r;
  logic [BIT_WIDTH-1:0]  y_nxt_s;
  logic [BIT_WIDTH-1:0]  avg_s;
  logic                  out_valid_r;
  logic                  out_valid_nxt_s;
  logic                  last_s;
  logic                  unused_bits_s;

  assign x_ext_s = {{LOG2_LEN{x[BIT_WIDTH-1]}}, x};
  assign sum_s   = acc_r + x_ext_s;

  // The final sample is folded into the average directly, so the result is
  // ready one edge after the last sample without an extra accumulate cycle.
  assign last_s = (state_r == ACCUM) && in_valid && (cnt_r == CNT_LAST);

`ifdef DETERM_ACCUM_ROUND_EN
  // One extra bit so adding half an LSB of the result can never wrap.
  localparam logic [ACC_W:0] HALF_LSB = {{ACC_W{1'b0}}, 1'b1} << (LOG2_LEN - 1);
  logic [ACC_W:0] sum_rnd_s;

  assign sum_rnd_s     = {sum_s[ACC_W-1], sum_s} + HALF_LSB;
  // Dropping the low LOG2_LEN bits is the arithmetic shift; the average always
  // fits BIT_WIDTH bits, so the top bits are pure sign copies.
  assign avg_s         = sum_rnd_s[ACC_W-1:LOG2_LEN];
  assign unused_bits_s = ^{sum_rnd_s[ACC_W], sum_rnd_s[LOG2_LEN-1:0]};
`else
  assign avg_s         = sum_s[ACC_W-1:LOG2_LEN];
  assign unused_bits_s = ^sum_s[LOG2_LEN-1:0];
`endif

  // Next-state and datapath update for the IDLE/ACCUM window controller.
  always_comb begin
    state_nxt_s     = state_r;
    acc_nxt_s       = acc_r;
    cnt_nxt_s       = cnt_r;
    y_nxt_s         = y_r;
    out_valid_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        // The sample arriving with start is deliberately not accumulated.
        if (start) begin
          state_nxt_s = ACCUM;
          acc_nxt_s   = '0;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (last_s) begin
          // The final sample belongs to the closing window even when start
          // opens the next one in the same cycle.
          y_nxt_s         = avg_s;
          out_valid_nxt_s = 1'b1;
          acc_nxt_s       = '0;
          cnt_nxt_s       = '0;
          if (start) begin
            state_nxt_s = ACCUM;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (start) begin
          // Abort: restart the window and drop this cycle's sample.
          acc_nxt_s = '0;
          cnt_nxt_s = '0;
        end else if (in_valid) begin
          acc_nxt_s = sum_s;
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          // Stall cycle, nothing changes.
          acc_nxt_s = acc_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        acc_nxt_s   = '0;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      cnt_r       <= '0;
      y_r         <= '0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      y_r         <= y_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  assign y         = y_r;
  assign out_valid = out_valid_r;
  assign busy      = (state_r == ACCUM);

endmodule

// File: tb/tb_determ_accum_fxp.sv
// tb_determ_accum_fxp
//   Self-checking bench for determ_accum_fxp with BIT_WIDTH=16, LOG2_LEN=2.
//   A window-level reference model (sample queue + integer average) predicts
//   y/out_valid/busy after every clock edge; directed scenarios are followed
//   by randomized traffic with occasional asynchronous resets.

module tb_determ_accum_fxp;

  localparam int BW = 16;
  localparam int L2 = 2;
  localparam int N  = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic          in_valid;
  logic [BW-1:0] x;
  logic [BW-1:0] y;
  logic          out_valid;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;

  // Reference model state
  bit m_active;
  int m_win[$];
  int m_y;
  bit m_ov;

  determ_accum_fxp #(.BIT_WIDTH(BW), .LOG2_LEN(L2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // Window average: floor(sum/N), or floor((sum+N/2)/N) when rounding.
  function automatic int avg(input int s);
    int t;
    t = s;
`ifdef DETERM_ACCUM_ROUND_EN
    t = t + N / 2;
`endif
    if (t >= 0) return t / N;
    else return -((-t + N - 1) / N);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_win.delete();
    m_y  = 0;
    m_ov = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit iv, input int xv);
    int s;
    m_ov = 1'b0;
    if (!m_active) begin
      if (st) begin
        m_active = 1'b1;
        m_win.delete();
      end
    end else if (iv && m_win.size() == N - 1) begin
      m_win.push_back(xv);
      s = 0;
      foreach (m_win[i]) s += m_win[i];
      m_y  = avg(s);
      m_ov = 1'b1;
      m_win.delete();
      m_active = st;
    end else if (st) begin
      m_win.delete();
    end else if (iv) begin
      m_win.push_back(xv);
    end
  endtask

  // One clock: drive on the falling edge, check #1 after the rising edge.
  task automatic cyc(input bit st, input bit iv, input int xv);
    int xs;
    logic [BW-1:0] xb;
    xb = xv[BW-1:0];
    xs = $signed(xb);
    @(negedge CLK);
    start    = st;
    in_valid = iv;
    x        = xb;
    @(posedge CLK);
    #1;
    model_step(st, iv, xs);
    if (out_valid === 1'b1) pulses++;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("busy", {31'd0, busy}, {31'd0, m_active});
    chk("y", $signed(y), m_y);
  endtask

  task automatic window(input int a, input int b, input int c, input int d);
    cyc(1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, a);
    cyc(1'b0, 1'b1, b);
    cyc(1'b0, 1'b1, c);
    cyc(1'b0, 1'b1, d);
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    chk({tag, "_y"}, $signed(y), 0);
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'sd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'sd0);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    int p0;
    RST      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    model_reset();
    #12;
    chk("rst_y", $signed(y), 0);
    chk("rst_ov", {31'd0, out_valid}, 32'sd0);
    chk("rst_busy", {31'd0, busy}, 32'sd0);
    @(negedge CLK);
    RST = 1'b0;
    cyc(1'b0, 1'b1, 77);

    // +1024 x3, -1024 -> 512
    p0 = pulses;
    window(1024, 1024, 1024, -1024);
    chk("t2_y", $signed(y), 512);
    chk("t2_pulse", pulses - p0, 1);
    cyc(1'b0, 1'b0, 0);
    chk("t2_ov_low", {31'd0, out_valid}, 32'sd0);

    // Reset with two samples in the window; no pulse may follow.
    p0 = pulses;
    cyc(1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 500);
    cyc(1'b0, 1'b1, 500);
    async_reset("t1");
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 500);
    chk("t1_nopulse", pulses - p0, 0);

    // Rounding corner cases
    window(3, 3, 3, -3);
`ifdef DETERM_ACCUM_ROUND_EN
    chk("t3_pos", $signed(y), 2);
`else
    chk("t3_pos", $signed(y), 1);
`endif
    window(-3, -3, -3, 3);
`ifdef DETERM_ACCUM_ROUND_EN
    chk("t3_neg", $signed(y), -1);
`else
    chk("t3_neg", $signed(y), -2);
`endif

    // Abort after two samples, then a full window of +100.
    p0 = pulses;
    cyc(1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 900);
    cyc(1'b0, 1'b1, 900);
    cyc(1'b1, 1'b1, 900);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 100);
    chk("t4_pulse", pulses - p0, 1);
    chk("t4_y", $signed(y), 100);

    // Back-to-back windows: start together with the final sample.
    p0 = pulses;
    cyc(1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 40);
    cyc(1'b0, 1'b1, 50);
    cyc(1'b0, 1'b1, 60);
    cyc(1'b1, 1'b1, 70);
    chk("t5_y1", $signed(y), 55);
    chk("t5_busy", {31'd0, busy}, 32'sd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, -8);
    chk("t5_y2", $signed(y), -8);
    chk("t5_pulse", pulses - p0, 2);

    // Gaps in in_valid
    cyc(1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 7);
    cyc(1'b0, 1'b0, 999);
    cyc(1'b0, 1'b0, 999);
    cyc(1'b0, 1'b1, 7);
    cyc(1'b0, 1'b1, 7);
    cyc(1'b0, 1'b0, 999);
    cyc(1'b0, 1'b1, 7);
    chk("t6_gap", $signed(y), 7);

    // Extremes
    window(32767, 32767, 32767, 32767);
    chk("t6_max", $signed(y), 32767);
    window(-32768, -32768, -32768, -32768);
    chk("t6_min", $signed(y), -32768);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499, 0) == 0) begin
        async_reset("rnd_rst");
      end else begin
        cyc($urandom_range(11, 0) == 0, $urandom_range(3, 0) != 0,
            int'($urandom_range(65535, 0)) - 32768);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
